// File: rtl/irq_controller.sv
// irq_controller: interrupt-source side of the CPU interrupt interface.
// Synchronizes and edge-detects raw IRQ lines and latches them as pending.
// It presents the highest-priority preempting request as int_req/int_id and
// tracks acknowledged handlers in in_service until their eoi arrives.
// Optional feature: define IRQ_DEBOUNCE_EN to add a per-line debounce filter
// of DEBOUNCE_CYCLES stable cycles ahead of the edge detector.
module irq_controller #(
    parameter int unsigned N_IRQ           = 3,
    parameter int unsigned ID_WIDTH        = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_IRQ-1:0]    irq_in,
    input  logic                int_ack,
    input  logic                int_eoi,
    output logic                int_req,
    output logic [ID_WIDTH-1:0] int_id,
    output logic [N_IRQ-1:0]    IRW,
    output logic [N_IRQ-1:0]    in_service
);

    // Priority levels are held as index+1 so that 0 stands for "nothing",
    // which is the unsigned equivalent of comparing against -1.
    localparam int unsigned LVL_W = ID_WIDTH + 1;

    if (N_IRQ < 1 || N_IRQ > (1 << ID_WIDTH) || DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
        $error("irq_controller: illegal N_IRQ / ID_WIDTH / DEBOUNCE_CYCLES");
    end

    logic [N_IRQ-1:0]    r_sync1;
    logic [N_IRQ-1:0]    r_sync2;
    logic [N_IRQ-1:0]    r_prev;
    logic [N_IRQ-1:0]    r_pending;
    logic [N_IRQ-1:0]    r_in_service;

    logic [N_IRQ-1:0]    w_level;
    logic [N_IRQ-1:0]    w_edge;
    logic [N_IRQ-1:0]    w_ack_mask;
    logic [N_IRQ-1:0]    w_eoi_mask;
    logic [LVL_W-1:0]    w_pend_lvl;
    logic [LVL_W-1:0]    w_svc_lvl;
    logic                w_req;
    logic [ID_WIDTH-1:0] w_id;

    // Two-flop synchronizer on every raw line.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= irq_in;
            r_sync2 <= r_sync1;
        end
    end

`ifdef IRQ_DEBOUNCE_EN
    localparam int unsigned         CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_IRQ-1:0] r_filtered;
    logic [CNT_W-1:0] r_cnt [N_IRQ];

    // Debounce: filtered follows sync2 only after it has disagreed for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_filtered <= '0;
            for (int unsigned i = 0; i < N_IRQ; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_IRQ; i++) begin
                if (r_sync2[i] != r_filtered[i]) begin
                    if (r_cnt[i] == CNT_LAST) begin
                        r_filtered[i] <= r_sync2[i];
                        r_cnt[i]      <= '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + 1'b1;
                    end
                end else begin
                    r_cnt[i] <= '0;
                end
            end
        end
    end

    assign w_level = r_filtered;
`else
    assign w_level = r_sync2;
`endif

    // Previous level for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= '0;
        end else begin
            r_prev <= w_level;
        end
    end

    assign w_edge = w_level & ~r_prev;

    // Highest set bit of pending and of in_service, as index+1 (0 = none).
    always_comb begin
        w_pend_lvl = '0;
        w_svc_lvl  = '0;
        for (int unsigned i = 0; i < N_IRQ; i++) begin
            if (r_pending[i]) begin
                w_pend_lvl = LVL_W'(i + 1);
            end
            if (r_in_service[i]) begin
                w_svc_lvl = LVL_W'(i + 1);
            end
        end
    end

    // Strict preemption: a request is eligible only above the active handler.
    always_comb begin
        w_req = (w_pend_lvl > w_svc_lvl);
        w_id  = '0;
        if (w_req) begin
            w_id = ID_WIDTH'(w_pend_lvl - 1'b1);
        end
    end

    // Ack moves the presented line to service; eoi retires the top handler.
    always_comb begin
        w_ack_mask = '0;
        w_eoi_mask = '0;
        if (int_ack && w_req) begin
            w_ack_mask = N_IRQ'(1) << w_id;
        end
        if (int_eoi && (w_svc_lvl != '0)) begin
            w_eoi_mask = N_IRQ'(1) << (w_svc_lvl - 1'b1);
        end
    end

    // Pending/in-service update; a new edge wins over a same-cycle ack clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending    <= '0;
            r_in_service <= '0;
        end else begin
            r_pending    <= (r_pending & ~w_ack_mask) | w_edge;
            r_in_service <= (r_in_service & ~w_eoi_mask) | w_ack_mask;
        end
    end

    assign int_req    = w_req;
    assign int_id     = w_id;
    assign IRW        = r_pending;
    assign in_service = r_in_service;

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed and randomized checks of irq_controller
// against a behavioural model of pending/in-service bookkeeping.
`timescale 1ns/1ps
module tb_irq_controller;

    localparam int N   = 3;
    localparam int IDW = 2;
    localparam int DB  = 4;
`ifdef IRQ_DEBOUNCE_EN
    localparam int LAT = 3 + DB;
`else
    localparam int LAT = 3;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   irq_in;
    logic           int_ack;
    logic           int_eoi;
    logic           int_req;
    logic [IDW-1:0] int_id;
    logic [N-1:0]   IRW;
    logic [N-1:0]   in_service;

    always #5 clk = ~clk;

    irq_controller #(
        .N_IRQ          (N),
        .ID_WIDTH       (IDW),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .irq_in    (irq_in),
        .int_ack   (int_ack),
        .int_eoi   (int_eoi),
        .int_req   (int_req),
        .int_id    (int_id),
        .IRW       (IRW),
        .in_service(in_service)
    );

    int checks   = 0;
    int failures = 0;

    // Model state: pending/in-service sets plus the input delay line.
    logic [N-1:0] m_pend  = '0;
    logic [N-1:0] m_isvc  = '0;
    logic [N-1:0] m_smp   = '0;
    logic [N-1:0] m_s     = '0;
    logic [N-1:0] m_lvl   = '0;
    logic [N-1:0] m_lvl_d = '0;
    int           m_run [N];

    function automatic int top_bit(input logic [N-1:0] v);
        int t = -1;
        for (int i = 0; i < N; i++) if (v[i]) t = i;
        return t;
    endfunction

    function automatic bit m_req();
        return top_bit(m_pend) > top_bit(m_isvc);
    endfunction

    function automatic int m_id();
        return m_req() ? top_bit(m_pend) : 0;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference behaviour, evaluated on the same edge as the DUT.
    always @(posedge clk) begin
        logic [N-1:0] ev;
        int tp, ts;
        if (rst) begin
            m_pend = '0; m_isvc = '0; m_smp = '0; m_s = '0;
            m_lvl = '0; m_lvl_d = '0;
            for (int i = 0; i < N; i++) m_run[i] = 0;
        end else begin
            ev = m_lvl & ~m_lvl_d;
            tp = top_bit(m_pend);
            ts = top_bit(m_isvc);
            if (int_eoi && ts >= 0) m_isvc[ts] = 1'b0;
            if (int_ack && tp > ts) begin
                m_pend[tp] = 1'b0;
                m_isvc[tp] = 1'b1;
            end
            m_pend  = m_pend | ev;
            m_lvl_d = m_lvl;
`ifdef IRQ_DEBOUNCE_EN
            for (int i = 0; i < N; i++) begin
                if (m_s[i] != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB) begin
                        m_lvl[i] = m_s[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
`endif
            m_s   = m_smp;
            m_smp = irq_in;
`ifndef IRQ_DEBOUNCE_EN
            m_lvl = m_s;
`endif
        end
    end

    // Every cycle: DUT outputs against the model.
    always @(negedge clk) begin
        chk("cyc.int_req",    int_req,    m_req());
        chk("cyc.int_id",     int_id,     m_id());
        chk("cyc.IRW",        IRW,        m_pend);
        chk("cyc.in_service", in_service, m_isvc);
    end

    // Hand-computed expectation applied to both the DUT and the model.
    task automatic lit(input string nm, input bit er, input int eid,
                       input logic [N-1:0] eirw, input logic [N-1:0] eisv);
        chk({nm, ".int_req"},    int_req,    er);
        chk({nm, ".int_id"},     int_id,     eid);
        chk({nm, ".IRW"},        IRW,        eirw);
        chk({nm, ".in_service"}, in_service, eisv);
        chk({nm, ".mdl_req"},    m_req(),    er);
        chk({nm, ".mdl_pend"},   m_pend,     eirw);
        chk({nm, ".mdl_isvc"},   m_isvc,     eisv);
    endtask

    // Apply inputs for one rising edge; return at the following falling edge.
    task automatic cyc(input bit r, input logic [N-1:0] q, input bit a, input bit e);
        rst = r; irq_in = q; int_ack = a; int_eoi = e;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic raise(input logic [N-1:0] q);
        cyc(0, q, 0, 0);
        cyc(0, '0, 0, 0);
        cyc(0, '0, 0, 0);
    endtask

    initial begin
        logic [N-1:0] nx;
        rst = 1'b1; irq_in = '1; int_ack = 1'b0; int_eoi = 1'b0;

        cyc(1, 3'b111, 0, 0); lit("rst1", 0, 0, 3'b000, 3'b000);
        cyc(1, 3'b111, 0, 0); lit("rst2", 0, 0, 3'b000, 3'b000);
        for (int k = 1; k <= LAT; k++) begin
            cyc(0, 3'b111, 0, 0);
            if (k == LAT - 1) lit("rel_early", 0, 0, 3'b000, 3'b000);
        end
        lit("rel_all", 1, 2, 3'b111, 3'b000);
        cyc(0, '0, 1, 0); lit("nest_ack2", 0, 0, 3'b011, 3'b100);
        cyc(0, '0, 0, 1); lit("nest_eoi2", 1, 1, 3'b011, 3'b000);
        cyc(0, '0, 1, 0); cyc(0, '0, 0, 1);
        cyc(0, '0, 1, 0); cyc(0, '0, 0, 1);
        lit("drained", 0, 0, 3'b000, 3'b000);

`ifndef IRQ_DEBOUNCE_EN
        cyc(0, 3'b001, 0, 0); cyc(0, 3'b001, 0, 0); cyc(0, 3'b000, 0, 0);
        lit("pulse0", 1, 0, 3'b001, 3'b000);
        cyc(0, '0, 1, 0); lit("pulse0_ack", 0, 0, 3'b000, 3'b001);
        cyc(0, '0, 0, 1); lit("pulse0_eoi", 0, 0, 3'b000, 3'b000);

        raise(3'b010); cyc(0, '0, 1, 0);
        raise(3'b001); lit("blocked0", 0, 0, 3'b001, 3'b010);
        raise(3'b100); lit("preempt2", 1, 2, 3'b101, 3'b010);
        cyc(0, '0, 1, 0); lit("ack2", 0, 0, 3'b001, 3'b110);
        cyc(0, '0, 0, 1); lit("eoi2", 0, 0, 3'b001, 3'b010);
        cyc(0, '0, 0, 1); lit("eoi1", 1, 0, 3'b001, 3'b000);
        cyc(0, '0, 1, 0); cyc(0, '0, 0, 1);

        raise(3'b001); cyc(0, '0, 1, 0);
        raise(3'b100); lit("pre_both", 1, 2, 3'b100, 3'b001);
        cyc(0, '0, 1, 1); lit("ack_eoi", 0, 0, 3'b000, 3'b100);
        cyc(0, '0, 0, 1);

        cyc(0, 3'b010, 0, 0); cyc(0, 3'b000, 0, 0); cyc(0, 3'b010, 0, 0);
        lit("edge1_a", 1, 1, 3'b010, 3'b000);
        cyc(0, 3'b000, 0, 0);
        cyc(0, 3'b000, 1, 0); lit("ack_vs_set", 0, 0, 3'b010, 3'b010);
        cyc(0, '0, 0, 1); cyc(0, '0, 1, 0); cyc(0, '0, 0, 1);

        cyc(0, '0, 1, 1); lit("idle_ack_eoi", 0, 0, 3'b000, 3'b000);
`else
        cyc(0, 3'b010, 0, 0); cyc(0, 3'b010, 0, 0);
        for (int k = 0; k < 12; k++) cyc(0, 3'b000, 0, 0);
        lit("glitch1", 0, 0, 3'b000, 3'b000);
        for (int k = 1; k <= 10; k++) begin
            cyc(0, 3'b010, 0, 0);
            if (k == LAT - 1) lit("db_early", 0, 0, 3'b000, 3'b000);
            if (k == LAT)     lit("db_set",   1, 1, 3'b010, 3'b000);
        end
        cyc(0, '0, 1, 0); cyc(0, '0, 0, 1);
`endif

        for (int c = 0; c < 4000; c++) begin
            nx = irq_in;
            for (int i = 0; i < N; i++) if ($urandom_range(7) == 0) nx[i] = ~nx[i];
            cyc($urandom_range(299) == 0, nx, $urandom_range(3) == 0, $urandom_range(5) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
